battleship_ctrl: RTL and testbench
==================================

BATTLESHIP_CTRL -- requirements
Module: battleship_ctrl

Interface
REQ-001 SHALL have parameter GRID_CELLS, default 100, number of valid grid cells (addresses 0..GRID_CELLS-1).
REQ-002 SHALL have parameter ADDR_W, default 7, cell address width; GRID_CELLS <= 2**ADDR_W.
REQ-003 SHALL have parameter NUM_SHIPS, default 5, ship cells to place and to sink; range 1..GRID_CELLS.
REQ-004 SHALL have one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-005 SHALL have ports (name direction width meaning):
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- center  in  1  debounced one-cycle action pulse
- cursorCor  in  ADDR_W  player cursor cell
- scanCor  in  ADDR_W  display scan cell
- Place_ADDR  out  ADDR_W  placement RAM address
- Place_DATA  out  2  placement RAM write data
- Place_RDATA  in  2  placement RAM read data, 1-cycle sync read
- Place_WE  out  1  placement RAM write enable
- Place_OE  out  1  placement RAM output enable
- Shoot_ADDR, Shoot_DATA, Shoot_RDATA, Shoot_WE, Shoot_OE  same as Place_*, shot RAM
- phase  out  2  00 CLEAR, 01 PLACE, 10 SHOOT, 11 OVER
- ships_left  out  $clog2(NUM_SHIPS+1)  unsunk ship cells
- shot_cnt  out  8  accepted shots, saturating
- game_over  out  1  high in OVER

Function
REQ-006 Cell codes SHALL be: Place RAM 00 empty, 01 ship; Shoot RAM 00 unshot, 01 miss, 10 hit.
REQ-007 States SHALL be CLEAR, P_IDLE, P_RD, P_CHK, S_IDLE, S_RD, S_CHK, OVER.
REQ-008 CLEAR SHALL write 00 to both RAMs at address clr_cnt, one cell per cycle, clr_cnt 0..GRID_CELLS-1, WE=1, OE=0; after the write to GRID_CELLS-1 go to P_IDLE (CLEAR lasts exactly GRID_CELLS cycles).
REQ-009 In P_IDLE/S_IDLE/OVER both ADDR outputs SHALL equal scanCor, WE=0, OE=1 (display reads).
REQ-010 center in P_IDLE with cursorCor < GRID_CELLS SHALL latch cursorCor and go to P_RD; cursorCor >= GRID_CELLS SHALL be ignored.
REQ-011 P_RD SHALL drive Place_ADDR=latched cell, OE=1; go to P_CHK.
REQ-012 P_CHK: Place_RDATA==00 SHALL write 01 (Place_WE=1 one cycle), increment placed count; Place_RDATA==01 SHALL write nothing (duplicate rejected); return to P_IDLE, or to S_IDLE when placed count reaches NUM_SHIPS.
REQ-013 center in S_IDLE with valid cursorCor SHALL latch it, go to S_RD driving both RAM addresses = latched cell, OE=1; then S_CHK.
REQ-014 S_CHK: Shoot_RDATA != 00 SHALL be ignored (no write, no count change); else write 10 if Place_RDATA==01 (decrement ships_left) or 01 otherwise; increment shot_cnt, saturating at 255.
REQ-015 S_CHK SHALL go to OVER when ships_left becomes 0, else S_IDLE.
REQ-016 center SHALL be ignored in every state except P_IDLE and S_IDLE; cursorCor changes after latch SHALL have no effect.
REQ-017 OVER SHALL be terminal until reset; game_over=1.
REQ-018 At most one WE per RAM SHALL be high per cycle outside CLEAR; Place_WE and Shoot_WE never both high outside CLEAR.
REQ-019 phase SHALL be 00 in CLEAR, 01 in P_*, 10 in S_*, 11 in OVER.

Reset
REQ-020 rst_n low SHALL immediately force: state CLEAR, clr_cnt 0, placed 0, ships_left NUM_SHIPS, shot_cnt 0, game_over 0, WE 0, OE 0.
REQ-021 Reset asserted mid-operation (any state, including mid-CLEAR) SHALL abort it; after release the full CLEAR sequence restarts at address 0.

Verification
REQ-022 Release rst_n -> WE high for exactly 100 cycles, addresses 0..99, data 00, then phase=01.
REQ-023 NUM_SHIPS=2: center at cell 5, center at cell 5 again, center at cell 9 -> Place writes 01 to 5 and 9 only; phase=10 after the third CHK.
REQ-024 In SHOOT, cursorCor=120 + center -> no RAM write, shot_cnt unchanged.
REQ-025 Shoot cell 3 (empty) -> Shoot write 01, shot_cnt=1; shoot cell 3 again -> no write, shot_cnt=1.
REQ-026 Shoot 5 then 9 -> writes 10 each, ships_left 2->1->0, phase=11, game_over=1; later center ignored.
REQ-027 Assert rst_n low during S_RD -> outputs reset values at once; on release CLEAR restarts at address 0.

Source files
------------

// File: rtl/battleship_ctrl_if.sv
// Bus bundle between the battleship game controller and its surroundings:
// player controls, display scan, the two game-board RAMs and game status.
interface battleship_ctrl_if #(
  parameter int ADDR_W    = 7,
  parameter int NUM_SHIPS = 5
);
  localparam int SL_W = $clog2(NUM_SHIPS + 1);

  // player / display side
  logic              center;
  logic [ADDR_W-1:0] cursorCor;
  logic [ADDR_W-1:0] scanCor;

  // placement RAM (00 empty, 01 ship)
  logic [ADDR_W-1:0] Place_ADDR;
  logic [1:0]        Place_DATA;
  logic [1:0]        Place_RDATA;
  logic              Place_WE;
  logic              Place_OE;

  // shot RAM (00 unshot, 01 miss, 10 hit)
  logic [ADDR_W-1:0] Shoot_ADDR;
  logic [1:0]        Shoot_DATA;
  logic [1:0]        Shoot_RDATA;
  logic              Shoot_WE;
  logic              Shoot_OE;

  // game status
  logic [1:0]        phase;
  logic [SL_W-1:0]   ships_left;
  logic [7:0]        shot_cnt;
  logic              game_over;

  // environment side: drives controls and RAM read data
  modport master (
    output center, cursorCor, scanCor, Place_RDATA, Shoot_RDATA,
    input  Place_ADDR, Place_DATA, Place_WE, Place_OE,
    input  Shoot_ADDR, Shoot_DATA, Shoot_WE, Shoot_OE,
    input  phase, ships_left, shot_cnt, game_over
  );

  // controller side
  modport slave (
    input  center, cursorCor, scanCor, Place_RDATA, Shoot_RDATA,
    output Place_ADDR, Place_DATA, Place_WE, Place_OE,
    output Shoot_ADDR, Shoot_DATA, Shoot_WE, Shoot_OE,
    output phase, ships_left, shot_cnt, game_over
  );
endinterface

// File: rtl/battleship_ctrl.sv
// Battleship game controller: clears both boards, lets the player place
// NUM_SHIPS ship cells, then takes shots until every ship cell is hit.
// Both board RAMs are external with a one-cycle synchronous read.
module battleship_ctrl #(
  parameter int GRID_CELLS = 100,
  parameter int ADDR_W     = 7,
  parameter int NUM_SHIPS  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  battleship_ctrl_if.slave bus
);
  localparam int SL_W = $clog2(NUM_SHIPS + 1);
  localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(GRID_CELLS - 1);
  localparam logic [ADDR_W:0]   GRID_LIM   = (ADDR_W + 1)'(GRID_CELLS);
  localparam logic [SL_W-1:0]   SHIPS_INIT = SL_W'(NUM_SHIPS);
  localparam logic [SL_W-1:0]   LAST_PLACE = SL_W'(NUM_SHIPS - 1);

  typedef enum logic [2:0] {
    CLEAR, P_IDLE, P_RD, P_CHK, S_IDLE, S_RD, S_CHK, OVER
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] clr_cnt_reg;
  logic [ADDR_W-1:0] cell_reg;
  logic [SL_W-1:0]   placed_reg;
  logic [SL_W-1:0]   ships_left_reg;
  logic [7:0]        shot_cnt_reg;

  logic cursor_ok, take_place, take_shot;
  logic place_new, shot_new, shot_hit;

  // Decisions shared by the FSM, the outputs and the counters. The CHK
  // states look at read data fetched during the preceding RD cycle.
  assign cursor_ok  = {1'b0, bus.cursorCor} < GRID_LIM;
  assign take_place = (state_reg == P_IDLE) && bus.center && cursor_ok;
  assign take_shot  = (state_reg == S_IDLE) && bus.center && cursor_ok;
  assign place_new  = (state_reg == P_CHK) && (bus.Place_RDATA == 2'b00);
  assign shot_new   = (state_reg == S_CHK) && (bus.Shoot_RDATA == 2'b00);
  assign shot_hit   = shot_new && (bus.Place_RDATA == 2'b01);

  assign bus.ships_left = ships_left_reg;
  assign bus.shot_cnt   = shot_cnt_reg;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= CLEAR;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      CLEAR:  if (clr_cnt_reg == LAST_CELL) state_next = P_IDLE;
      P_IDLE: if (take_place) state_next = P_RD;
      P_RD:   state_next = P_CHK;
      P_CHK:  state_next = (place_new && placed_reg == LAST_PLACE) ? S_IDLE : P_IDLE;
      S_IDLE: if (take_shot) state_next = S_RD;
      S_RD:   state_next = S_CHK;
      S_CHK:  state_next = (shot_hit && ships_left_reg == SL_W'(1)) ? OVER : S_IDLE;
      OVER:   state_next = OVER;
      default: state_next = CLEAR;
    endcase
  end

  // RAM control and status outputs; reset forces every enable low at once
  always_comb begin
    bus.Place_ADDR = '0;
    bus.Place_DATA = 2'b00;
    bus.Place_WE   = 1'b0;
    bus.Place_OE   = 1'b0;
    bus.Shoot_ADDR = '0;
    bus.Shoot_DATA = 2'b00;
    bus.Shoot_WE   = 1'b0;
    bus.Shoot_OE   = 1'b0;
    bus.phase      = 2'b00;
    bus.game_over  = 1'b0;
    if (rst_n) begin
      case (state_reg)
        CLEAR: begin
          bus.Place_ADDR = clr_cnt_reg;
          bus.Shoot_ADDR = clr_cnt_reg;
          bus.Place_WE   = 1'b1;
          bus.Shoot_WE   = 1'b1;
        end
        P_IDLE, S_IDLE, OVER: begin
          bus.Place_ADDR = bus.scanCor;
          bus.Shoot_ADDR = bus.scanCor;
          bus.Place_OE   = 1'b1;
          bus.Shoot_OE   = 1'b1;
        end
        P_RD: begin
          bus.Place_ADDR = cell_reg;
          bus.Shoot_ADDR = cell_reg;
          bus.Place_OE   = 1'b1;
        end
        P_CHK: begin
          bus.Place_ADDR = cell_reg;
          bus.Shoot_ADDR = cell_reg;
          bus.Place_DATA = 2'b01;
          bus.Place_WE   = place_new;
        end
        S_RD, S_CHK: begin
          bus.Place_ADDR = cell_reg;
          bus.Shoot_ADDR = cell_reg;
          bus.Place_OE   = 1'b1;
          bus.Shoot_OE   = 1'b1;
          bus.Shoot_DATA = shot_hit ? 2'b10 : 2'b01;
          bus.Shoot_WE   = shot_new;
        end
        default: ;
      endcase
      case (state_reg)
        P_IDLE, P_RD, P_CHK: bus.phase = 2'b01;
        S_IDLE, S_RD, S_CHK: bus.phase = 2'b10;
        OVER:                bus.phase = 2'b11;
        default:             bus.phase = 2'b00;
      endcase
      bus.game_over = (state_reg == OVER);
    end
  end

  // Clear pointer, latched target cell and game counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt_reg    <= '0;
      cell_reg       <= '0;
      placed_reg     <= '0;
      ships_left_reg <= SHIPS_INIT;
      shot_cnt_reg   <= '0;
    end else begin
      if (state_reg == CLEAR) clr_cnt_reg <= clr_cnt_reg + 1'b1;
      if (take_place || take_shot) cell_reg <= bus.cursorCor;
      if (place_new) placed_reg <= placed_reg + 1'b1;
      if (shot_hit) ships_left_reg <= ships_left_reg - 1'b1;
      if (shot_new && shot_cnt_reg != 8'hFF) shot_cnt_reg <= shot_cnt_reg + 1'b1;
    end
  end
endmodule

// File: tb/tb_battleship_ctrl.sv
// Bench for battleship_ctrl: two behavioural board RAMs, a game-rule
// reference model, directed scenarios and randomized games.
module tb_battleship_ctrl;
  localparam int GRID = 100;
  localparam int AW   = 7;
  localparam int NS   = 2;
  localparam int SLW  = $clog2(NS + 1);
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  battleship_ctrl_if #(.ADDR_W(AW), .NUM_SHIPS(NS)) bus ();

  battleship_ctrl #(.GRID_CELLS(GRID), .ADDR_W(AW), .NUM_SHIPS(NS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Board RAMs: registered read when OE, write when WE; junk while in reset
  logic [1:0] place_mem [0:DEPTH-1];
  logic [1:0] shoot_mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        place_mem[i] <= 2'b11;
        shoot_mem[i] <= 2'b11;
      end
    end else begin
      if (bus.Place_OE) bus.Place_RDATA <= place_mem[bus.Place_ADDR];
      if (bus.Place_WE) place_mem[bus.Place_ADDR] <= bus.Place_DATA;
      if (bus.Shoot_OE) bus.Shoot_RDATA <= shoot_mem[bus.Shoot_ADDR];
      if (bus.Shoot_WE) shoot_mem[bus.Shoot_ADDR] <= bus.Shoot_DATA;
    end
  end

  // Write monitor outside the clearing phase
  int place_wr_cnt = 0;
  int shoot_wr_cnt = 0;
  int both_we_cnt  = 0;
  always @(posedge clk) begin
    if (rst_n && bus.phase != 2'b00) begin
      if (bus.Place_WE) place_wr_cnt++;
      if (bus.Shoot_WE) shoot_wr_cnt++;
      if (bus.Place_WE && bus.Shoot_WE) both_we_cnt++;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: game rules over plain arrays
  bit         ref_ship [0:GRID-1];
  logic [1:0] ref_shot [0:GRID-1];
  int ref_phase, ref_placed, ref_left, ref_shots;

  task automatic ref_reset();
    for (int i = 0; i < GRID; i++) begin
      ref_ship[i] = 1'b0;
      ref_shot[i] = 2'b00;
    end
    ref_phase  = 1;
    ref_placed = 0;
    ref_left   = NS;
    ref_shots  = 0;
  endtask

  task automatic ref_action(input int c, output int pw, output int sw);
    pw = 0;
    sw = 0;
    if (c < GRID) begin
      if (ref_phase == 1) begin
        if (!ref_ship[c]) begin
          ref_ship[c] = 1'b1;
          ref_placed++;
          pw = 1;
          if (ref_placed == NS) ref_phase = 2;
        end
      end else if (ref_phase == 2) begin
        if (ref_shot[c] == 2'b00) begin
          ref_shot[c] = ref_ship[c] ? 2'b10 : 2'b01;
          sw = 1;
          if (ref_shots < 255) ref_shots++;
          if (ref_ship[c]) begin
            ref_left--;
            if (ref_left == 0) ref_phase = 3;
          end
        end
      end
    end
  endtask

  // Values forced while reset is held
  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ctl"}, {bus.Place_WE, bus.Shoot_WE, bus.Place_OE, bus.Shoot_OE,
                              bus.phase, bus.game_over}, 32'd0);
    check_val({tag, "_cnt"}, {bus.ships_left, bus.shot_cnt}, {SLW'(NS), 8'd0});
  endtask

  // Release reset and follow the full clear sweep (center held high throughout)
  task automatic run_clear();
    int bad_p, bad_s;
    @(negedge clk);
    rst_n = 1'b1;
    bus.center = 1'b1;
    bus.cursorCor = AW'(11);
    for (int i = 0; i < GRID; i++) begin
      #1;
      check_val("clr_ctl", {bus.Place_WE, bus.Shoot_WE, bus.Place_OE, bus.Shoot_OE,
                            bus.Place_DATA, bus.Shoot_DATA, bus.phase}, 32'b1100_0000_00);
      check_val("clr_addr", {bus.Place_ADDR, bus.Shoot_ADDR}, {AW'(i), AW'(i)});
      if (i == GRID - 1) bus.center = 1'b0;
      @(negedge clk);
    end
    #1;
    check_val("clr_done", {bus.phase, bus.Place_WE, bus.Shoot_WE}, {2'b01, 2'b00});
    bad_p = 0;
    bad_s = 0;
    for (int i = 0; i < GRID; i++) begin
      if (place_mem[i] !== 2'b00) bad_p++;
      if (shoot_mem[i] !== 2'b00) bad_s++;
    end
    check_val("clr_ram", {bad_p[15:0], bad_s[15:0]}, 32'd0);
    $display("clear sweep done: %0d cells, phase=%0d", GRID, bus.phase);
  endtask

  // One player action: center pulse at cell c, optional extra center while busy
  task automatic do_action(input int c, input bit noise_in);
    int pw0, sw0, epw, esw, scan;
    bit noise;
    noise = noise_in && (c < GRID) && (ref_phase == 1 || ref_phase == 2);
    scan = $urandom_range(0, GRID - 1);
    @(negedge clk);
    pw0 = place_wr_cnt;
    sw0 = shoot_wr_cnt;
    bus.scanCor   = AW'(scan);
    bus.cursorCor = AW'(c);
    bus.center    = 1'b1;
    @(negedge clk);
    bus.center    = noise;
    bus.cursorCor = AW'($urandom_range(0, GRID - 1));
    @(negedge clk);
    @(negedge clk);
    bus.center = 1'b0;
    @(negedge clk);
    ref_action(c, epw, esw);
    check_val("wr_place", place_wr_cnt - pw0, epw);
    check_val("wr_shoot", shoot_wr_cnt - sw0, esw);
    check_val("phase", bus.phase, ref_phase);
    check_val("game_over", bus.game_over, (ref_phase == 3) ? 1 : 0);
    check_val("ships_left", bus.ships_left, ref_left);
    check_val("shot_cnt", bus.shot_cnt, ref_shots);
    check_val("display", {bus.Place_ADDR, bus.Shoot_ADDR, bus.Place_OE, bus.Shoot_OE,
                          bus.Place_WE, bus.Shoot_WE}, {AW'(scan), AW'(scan), 4'b1100});
    if (c < GRID) begin
      check_val("cell_place", place_mem[c], {1'b0, ref_ship[c]});
      check_val("cell_shoot", shoot_mem[c], ref_shot[c]);
    end
    $display("action cell=%0d phase=%0d ships_left=%0d shots=%0d", c, bus.phase,
             bus.ships_left, bus.shot_cnt);
  endtask

  task automatic check_boards(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < GRID; i++) begin
      if (place_mem[i] !== {1'b0, ref_ship[i]}) bad++;
      if (shoot_mem[i] !== ref_shot[i]) bad++;
    end
    check_val(tag, bad, 0);
  endtask

  initial begin
    int c, r;
    bus.center = 1'b0;
    bus.cursorCor = '0;
    bus.scanCor = '0;
    ref_reset();
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("rst_init");

    // reset in the middle of the clear sweep restarts it from address 0
    @(negedge clk);
    rst_n = 1'b1;
    repeat (37) @(negedge clk);
    #1 check_val("clr_mid_addr", bus.Place_ADDR, 37);
    rst_n = 1'b0;
    #1 check_reset_outputs("rst_midclr");
    repeat (2) @(negedge clk);
    run_clear();

    // placement with a duplicate, then directed shots
    do_action(5, 1'b0);
    do_action(5, 1'b0);
    do_action(9, 1'b0);
    do_action(120, 1'b1);
    do_action(3, 1'b1);
    do_action(3, 1'b0);
    do_action(5, 1'b1);
    do_action(9, 1'b0);
    do_action(7, 1'b0);
    do_action(42, 1'b0);
    check_boards("boards_directed");

    // reset while a shot read is in flight
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    ref_reset();
    run_clear();
    do_action(1, 1'b0);
    do_action(2, 1'b0);
    do_action(50, 1'b0);
    do_action(1, 1'b0);
    @(negedge clk);
    bus.cursorCor = AW'(4);
    bus.center = 1'b1;
    @(posedge clk);
    #1;
    check_val("s_rd_bus", {bus.Shoot_ADDR, bus.Shoot_OE, bus.Shoot_WE}, {AW'(4), 2'b10});
    rst_n = 1'b0;
    #1 check_reset_outputs("rst_s_rd");
    bus.center = 1'b0;
    repeat (2) @(negedge clk);
    ref_reset();
    run_clear();

    // randomized games
    for (int g = 0; g < 4; g++) begin
      if (g != 0) begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        ref_reset();
        run_clear();
      end
      for (int n = 0; n < 400 && ref_phase != 3; n++) begin
        r = $urandom_range(0, 9);
        if (r == 0)     c = $urandom_range(GRID, DEPTH - 1);
        else if (r < 5) c = $urandom_range(0, 9);
        else            c = $urandom_range(0, GRID - 1);
        do_action(c, 1'($urandom_range(0, 1)));
      end
      do_action($urandom_range(0, GRID - 1), 1'b0);
      do_action($urandom_range(0, GRID - 1), 1'b0);
      check_boards("boards_random");
    end

    check_val("both_we", both_we_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
